// File: rtl/alu_div8_pkg.sv
// Shared ALU definitions for the sequential divider: datapath width,
// divider FSM state encoding and the divide-by-zero quotient constant.
package alu_div8_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Quotient reported when the divisor is zero (all ones at ALU width).
  localparam logic [ALU_W-1:0] DIV0_Q = {ALU_W{1'b1}};

endpackage : alu_div8_pkg

// File: rtl/alu_div8_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, using an XOR-inverted-B ripple adder with
// carry-in 1. The remainder is restored when the subtract borrows.
module div_sub_step
  import alu_div8_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH:0]   rs,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  logic [WIDTH:0] b_inv;
  logic [WIDTH:0] carry;
  logic [WIDTH:0] t;

  // Ripple subtract rs - {0,d} and pick trial or restored remainder.
  // NOTE: combinational blocks use blocking '=' so each carry is visible to
  // the next bit within the same evaluation; every output gets a default first
  // so no latch can be inferred.
  always_comb begin
    b_inv    = {1'b0, d} ^ {(WIDTH + 1){1'b1}};
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = (rs[i] & b_inv[i]) | (carry[i] & (rs[i] ^ b_inv[i]));
    end
    t = '0;
    for (int i = 0; i <= WIDTH; i++) begin
      t[i] = rs[i] ^ b_inv[i] ^ carry[i];
    end
    // Top sum bit set means rs < d (borrow), so the quotient bit is 0.
    q_bit  = ~t[WIDTH];
    r_next = q_bit ? t[WIDTH-1:0] : rs[WIDTH-1:0];
  end

endmodule : div_sub_step

// File: rtl/alu_div8.sv
// Sequential unsigned restoring divider for the 8-bit ALU. One quotient bit
// per cycle, start/done handshake, results held until the next completion.
module alu_div8
  import alu_div8_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_DIV_Q = {WIDTH{1'b1}};

  div_state_t       state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   rs;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             q_bit;

  // Shift the next dividend bit into the partial remainder.
  assign rs     = {r_q, q_q[WIDTH-1]};
  assign q_next = {q_q[WIDTH-2:0], q_bit};

  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rs     (rs),
    .d      (d_q),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  // Divider FSM with step counter, working registers and registered outputs.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= DIV_IDLE;
      count       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor != '0) begin
              state <= DIV_RUN;
              q_q   <= dividend;
              r_q   <= '0;
              d_q   <= divisor;
              count <= '0;
            end else begin
              // Zero divisor completes immediately with a flagged result.
              state       <= DIV_DONE;
              done        <= 1'b1;
              quotient    <= ZERO_DIV_Q;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end

        DIV_RUN: begin
          r_q   <= r_next;
          q_q   <= q_next;
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            // Publish the final step's result directly on entry to DONE.
            state       <= DIV_DONE;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end

        DIV_DONE: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : alu_div8

// File: tb/tb_alu_div8.sv
// Self-checking bench for alu_div8: table-driven vectors, hand-written
// multi-cycle sequences and a random sweep, with a result scoreboard.
module tb_alu_div8;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests;
  int fails;
  exp_t sb_q[$];
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  alu_div8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse consumes the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_quotient", {24'd0, quotient}, {24'd0, e.q});
        check("sb_remainder", {24'd0, remainder}, {24'd0, e.r});
        check("sb_div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
      end
    end
  end

  // Called #1 after a rising edge in an idle cycle (cycle 0). Returns #1
  // after the edge that starts the first idle cycle following done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input string tag);
    int lat;
    exp_t e;
    lat = (b == 0) ? 1 : W + 1;
    e.q = eq; e.r = er; e.dz = edz;
    sb_q.push_back(e);
    start = 1'b1; dividend = a; divisor = b;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0;
        dividend = W'($urandom);
        divisor = W'($urandom);
      end
      check($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, 32'd1);
      check($sformatf("%s_done_c%0d", tag, c), {31'd0, done}, {31'd0, (c == lat)});
      if (c < lat) begin
        check($sformatf("%s_hold_q_c%0d", tag, c), {24'd0, quotient}, {24'd0, last_q});
        check($sformatf("%s_hold_r_c%0d", tag, c), {24'd0, remainder}, {24'd0, last_r});
      end
    end
    @(posedge clk); #1;
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_done"}, {31'd0, done}, 32'd0);
    check({tag, "_held_q"}, {24'd0, quotient}, {24'd0, eq});
    check({tag, "_held_r"}, {24'd0, remainder}, {24'd0, er});
    check({tag, "_held_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int done_cnt;
    int done_at;
    int stray;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0]  = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   dz: 1'b0};
    vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0};
    vecs[2]  = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dz: 1'b0};
    vecs[3]  = '{a: 8'd200, b: 8'd0,   q: 8'hFF,  r: 8'd200, dz: 1'b1};
    vecs[4]  = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   dz: 1'b0};
    vecs[5]  = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dz: 1'b0};
    vecs[6]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0};
    vecs[7]  = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1,   dz: 1'b0};
    vecs[8]  = '{a: 8'd128, b: 8'd16,  q: 8'd8,   r: 8'd0,   dz: 1'b0};
    vecs[9]  = '{a: 8'd254, b: 8'd127, q: 8'd2,   r: 8'd0,   dz: 1'b0};
    vecs[10] = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0,   dz: 1'b1};
    vecs[11] = '{a: 8'd250, b: 8'd128, q: 8'd1,   r: 8'd122, dz: 1'b0};

    tests = 0; fails = 0;
    last_q = '0; last_r = '0;

    // Reset with start held high: reset must win and clear every output.
    rst_n = 1'b0; start = 1'b1; dividend = 8'd10; divisor = 8'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    // Table vectors issued back-to-back in the first idle cycle each time.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz,
             $sformatf("vec%0d", i));
    end

    // start re-pulsed in cycles 3 and 9 of 50/5 must be ignored.
    sb_q.push_back('{q: 8'd10, r: 8'd0, dz: 1'b0});
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      start = (c == 3 || c == 9);
      dividend = 8'd99;
      divisor = (c == 9) ? 8'd0 : 8'd1;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      check($sformatf("ign_busy_c%0d", c), {31'd0, busy}, {31'd0, (c <= 9)});
    end
    start = 1'b0;
    check("ign_done_count", done_cnt, 1);
    check("ign_done_cycle", done_at, 9);
    last_q = 8'd10; last_r = 8'd0;

    // Reset asserted in cycle 4 of 77/6 abandons the divide.
    sb_q.push_back('{q: 8'd12, r: 8'd5, dz: 1'b0});
    start = 1'b1; dividend = 8'd77; divisor = 8'd6;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb_q.delete();
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_quotient", {24'd0, quotient}, 32'd0);
    check("mid_rst_remainder", {24'd0, remainder}, 32'd0);
    check("mid_rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy) stray++;
    end
    check("mid_rst_no_done", stray, 0);
    last_q = '0; last_r = '0;
    run_op(8'd77, 8'd6, 8'd12, 8'd5, 1'b0, "after_rst");

    // Every divisor once with a random dividend, then random pairs.
    for (int i = 0; i < 256; i++) begin
      ra = W'($urandom);
      rb = W'(i);
      if (rb == 0) run_op(ra, rb, 8'hFF, ra, 1'b1, "sweep");
      else         run_op(ra, rb, ra / rb, ra % rb, 1'b0, "sweep");
    end
    for (int i = 0; i < 400; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : W'($urandom);
      if (rb == 0) run_op(ra, rb, 8'hFF, ra, 1'b1, "rand");
      else         run_op(ra, rb, ra / rb, ra % rb, 1'b0, "rand");
    end

    @(posedge clk); #1;
    check("sb_pending", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_div8
